conv_bus_arb: RTL and testbench
===============================

# conv_bus_arb

Parametrised bus arbiter/multiplexer that replaces per-unit tristate link gating inside the convolution unit. It merges N_PORT client request channels (read bridges, write bridges) onto the single shared system address bus, and owns each granted transaction through its full data phase. Read data is broadcast and qualified per client. Write data, strobes and lengths are multiplexed from the owning client.

## Interface
- N_PORT, 3, number of clients (≥2); port 0 has highest priority after reset
- ADDR_W, 28, address width
- DATA_W, 32, data width; strobe width DATA_W/8
- LEN_W, 4, burst length field width (beats-1)
- ID_W, 4, transaction id width
---
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- cl_valid  in  [N_PORT]  client request valid
- cl_write  in  [N_PORT]  1=write, 0=read
- cl_addr  in  [N_PORT][ADDR_W]  start address
- cl_len  in  [N_PORT][LEN_W]  beats-1
- cl_id  in  [N_PORT][ID_W]  user id
- cl_ap  in  [N_PORT]  user ap bit
- cl_ready  out  [N_PORT]  request accepted by bus
- cl_wdata  in  [N_PORT][DATA_W]  write data
- cl_wstrb  in  [N_PORT][DATA_W/8]  write strobes
- cl_wready  out  [N_PORT]  write beat consumed
- cl_rvalid  out  [N_PORT]  read beat valid for this client
- cl_rlast  out  [N_PORT]  last read beat for this client
- rdata_o  out  DATA_W  read data broadcast (= rdata)
- addr  out  ADDR_W  shared address bus
- arvalid, arready  out/in  1  read address handshake
- awvalid, awready  out/in  1  write address handshake
- arlen/awlen, aruser_id/awuser_id, aruser_ap/awuser_ap  out  LEN_W/ID_W/1
- rdata  in  DATA_W; rvalid, rlast  in  1; rid  in  ID_W
- wdata  out  DATA_W; wstrb  out  DATA_W/8; wready, wuser_last  in  1; wuser_id  in  ID_W
- busy  out  1  state ≠ IDLE
- err  out  1  sticky protocol error (only with checker compiled in; else tied 0)

## Operation
- FSM: IDLE → ADDR → RDATA | WDATA → IDLE.
- IDLE: if any cl_valid, pick the first requester at or after rr_ptr (round robin), register grant, and go to ADDR. rr_ptr ← grant+1 mod N_PORT.
- ADDR: drive addr/len/id/ap from the granted client. arvalid=1 if read, awvalid=1 if write; the other valid is 0. Hold until ready. In the ready cycle, cl_ready[grant]=1 (combinational). Then go to RDATA or WDATA.
- RDATA: cl_rvalid[grant]=rvalid, cl_rlast[grant]=rvalid&rlast. Exit on rvalid&rlast.
- WDATA: wdata/wstrb=cl_wdata/cl_wstrb[grant], cl_wready[grant]=wready. Exit on wready&wuser_last.
- Grant is locked ADDR through data phase; cl_valid changes of other ports are ignored.
- Outside WDATA: wstrb=0, wdata=0. Outside RDATA: all cl_rvalid=0. Bus beats arriving in the wrong state are dropped.
- Reset values: addr 0, all valids 0, lens/ids/ap 0, wdata/wstrb 0, cl_ready/cl_wready/cl_rvalid/cl_rlast 0, busy 0, err 0, rr_ptr 0, state IDLE.

## Timing
- Request seen in IDLE at cycle t → arvalid/awvalid registered high at t+1.
- Address outputs are registered; cl_ready, cl_wready and cl_rvalid are combinational from bus inputs.
- Mandatory IDLE cycle between transactions: minimum 3 cycles per single-beat transfer.
- Simultaneous requests: round-robin order. With all N_PORT requesting continuously, grants cycle 0,1,2,…
- Reset asserted mid-transaction: immediate return to reset values; in-flight burst abandoned.

## Configuration
- CONV_ARB_BEATCHK_EN defined: an LEN_W+1-bit beat counter checks that the last beat arrives exactly at beat cl_len+1. It also checks rid/wuser_id against the granted id, and flags any bus beat outside its data state. Any mismatch sets err sticky until reset. The FSM still exits on the last flag.
- Not defined: no counter, no checks, err=0.

## Structure
- Package conv_pkg holds:
  - arb_state_t enum {IDLE, ADDR, RDATA, WDATA}
  - default LEN_W/ID_W/ADDR_W constants
- Sub-module conv_rr_pick: combinational round-robin picker (req vector, rr_ptr → one-hot grant + index, any).

## Test plan
- Single read from port 1, len=3, arready after 2 cycles → arvalid at t+1, cl_ready[1] pulse when arready, 4 cl_rvalid[1] beats, busy low the cycle after rlast.
- Ports 0,1,2 request simultaneously, alternating read/write → grant order 0,1,2, then back to 0 on re-request. awvalid/arvalid never both high.
- Write port 2, len=1, data 0xA5A5_0001/0002, wready stalls one cycle between beats → wdata/wstrb sourced from port 2 only, cl_wready[2] mirrors wready, exit on wuser_last.
- Stray rvalid while in WDATA → no cl_rvalid. With CONV_ARB_BEATCHK_EN, err=1 and stays set.
- rlast on beat 2 of len=3 (macro on) → FSM returns IDLE, err=1. rid≠cl_id → err=1.
- rst_n low during RDATA beat 2 → all outputs at reset values asynchronously. Next request from port 0 is served first.

Source files
------------

// File: rtl/conv_bus_arb_pkg.sv
// Shared types and default widths for the convolution-unit bus arbiter.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } arb_state_t;

    localparam int N_PORT_DEF = 3;
    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 4;
    localparam int ID_W_DEF   = 4;

endpackage

// File: rtl/conv_bus_arb_if.sv
// Shared system bus between the arbiter (master) and the memory side (slave).
interface conv_bus_arb_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 4
) ();
    logic [ADDR_W-1:0]   addr;
    logic                arvalid;
    logic                arready;
    logic                awvalid;
    logic                awready;
    logic [LEN_W-1:0]    arlen;
    logic [LEN_W-1:0]    awlen;
    logic [ID_W-1:0]     aruser_id;
    logic [ID_W-1:0]     awuser_id;
    logic                aruser_ap;
    logic                awuser_ap;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                rlast;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wready;
    logic                wuser_last;
    logic [ID_W-1:0]     wuser_id;

    modport master (
        output addr, arvalid, awvalid, arlen, awlen, aruser_id, awuser_id,
               aruser_ap, awuser_ap, wdata, wstrb,
        input  arready, awready, rdata, rvalid, rlast, rid, wready,
               wuser_last, wuser_id
    );

    modport slave (
        input  addr, arvalid, awvalid, arlen, awlen, aruser_id, awuser_id,
               aruser_ap, awuser_ap, wdata, wstrb,
        output arready, awready, rdata, rvalid, rlast, rid, wready,
               wuser_last, wuser_id
    );
endinterface

// File: rtl/conv_bus_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module conv_rr_pick #(
    parameter int N_PORT = 3,
    parameter int IDX_W  = 2
) (
    input  logic [N_PORT-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [N_PORT-1:0] gnt_oh,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any
);
    int         k_s;
    logic [IDX_W-1:0] k_idx_s;

    // Scan the ports starting at ptr, wrapping once.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k_s     = 0;
        k_idx_s = '0;
        for (int i = 0; i < N_PORT; i++) begin
            k_s = int'(ptr) + i;
            if (k_s >= N_PORT) begin
                k_s = k_s - N_PORT;
            end else begin
                k_s = k_s;
            end
            k_idx_s = IDX_W'(k_s);
            if (!any && req[k_idx_s]) begin
                any             = 1'b1;
                gnt_idx         = k_idx_s;
                gnt_oh[k_idx_s] = 1'b1;
            end else begin
                any = any;
            end
        end
    end
endmodule

// File: rtl/conv_bus_arb.sv
// Round-robin arbiter that owns each granted transaction through its data phase.
// Optional beat/id checker enabled by defining CONV_ARB_BEATCHK_EN.
module conv_bus_arb
    import conv_pkg::*;
#(
    parameter int N_PORT = N_PORT_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_PORT-1:0]                  cl_valid,
    input  logic [N_PORT-1:0]                  cl_write,
    input  logic [N_PORT-1:0][ADDR_W-1:0]      cl_addr,
    input  logic [N_PORT-1:0][LEN_W-1:0]       cl_len,
    input  logic [N_PORT-1:0][ID_W-1:0]        cl_id,
    input  logic [N_PORT-1:0]                  cl_ap,
    output logic [N_PORT-1:0]                  cl_ready,
    input  logic [N_PORT-1:0][DATA_W-1:0]      cl_wdata,
    input  logic [N_PORT-1:0][DATA_W/8-1:0]    cl_wstrb,
    output logic [N_PORT-1:0]                  cl_wready,
    output logic [N_PORT-1:0]                  cl_rvalid,
    output logic [N_PORT-1:0]                  cl_rlast,
    output logic [DATA_W-1:0]                  rdata_o,
    conv_bus_arb_if.master                     bus,
    output logic                               busy,
    output logic                               err
);
    localparam int IDX_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic                   write_q, write_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   ap_q, ap_d, arvalid_q, arvalid_d, awvalid_q, awvalid_d;
    logic [N_PORT-1:0]      pick_oh_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_any_s, addr_hs_s;
    logic [DATA_W-1:0]      wdata_s;
    logic [DATA_W/8-1:0]    wstrb_s;

    conv_rr_pick #(.N_PORT(N_PORT), .IDX_W(IDX_W)) u_pick (
        .req(cl_valid), .ptr(rr_ptr_q),
        .gnt_oh(pick_oh_s), .gnt_idx(pick_idx_s), .any(pick_any_s)
    );

    assign addr_hs_s = (arvalid_q & bus.arready) | (awvalid_q & bus.awready);

    // State register and registered address-phase fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            ap_q      <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            id_q      <= id_d;
            ap_q      <= ap_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any_s) state_d = ADDR; else state_d = IDLE;
            ADDR:    if (addr_hs_s) state_d = write_q ? WDATA : RDATA; else state_d = ADDR;
            RDATA:   if (bus.rvalid && bus.rlast) state_d = IDLE; else state_d = RDATA;
            WDATA:   if (bus.wready && bus.wuser_last) state_d = IDLE; else state_d = WDATA;
            default: state_d = IDLE;
        endcase
    end

    // Grant capture in IDLE; address valids drop after the handshake.
    always_comb begin
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        write_d   = write_q;
        addr_d    = addr_q;
        len_d     = len_q;
        id_d      = id_q;
        ap_d      = ap_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    grant_d   = pick_idx_s;
                    rr_ptr_d  = (pick_idx_s == IDX_W'(N_PORT - 1)) ? '0 : pick_idx_s + 1'b1;
                    write_d   = |(pick_oh_s & cl_write);
                    addr_d    = cl_addr[pick_idx_s];
                    len_d     = cl_len[pick_idx_s];
                    id_d      = cl_id[pick_idx_s];
                    ap_d      = cl_ap[pick_idx_s];
                    arvalid_d = ~write_d;
                    awvalid_d = write_d;
                end else begin
                    grant_d = grant_q;
                end
            end
            ADDR: begin
                if (addr_hs_s) begin
                    arvalid_d = 1'b0;
                    awvalid_d = 1'b0;
                end else begin
                    arvalid_d = arvalid_q;
                end
            end
            default: begin
                grant_d = grant_q;
            end
        endcase
    end

    // Per-client qualifiers and write-data mux, live only in the owning state.
    always_comb begin
        cl_ready  = '0;
        cl_wready = '0;
        cl_rvalid = '0;
        cl_rlast  = '0;
        wdata_s   = '0;
        wstrb_s   = '0;
        case (state_q)
            ADDR:  cl_ready[grant_q] = addr_hs_s;
            RDATA: begin
                cl_rvalid[grant_q] = bus.rvalid;
                cl_rlast[grant_q]  = bus.rvalid & bus.rlast;
            end
            WDATA: begin
                cl_wready[grant_q] = bus.wready;
                wdata_s            = cl_wdata[grant_q];
                wstrb_s            = cl_wstrb[grant_q];
            end
            default: cl_ready = '0;
        endcase
    end

    assign bus.addr      = addr_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.awvalid   = awvalid_q;
    assign bus.arlen     = len_q;
    assign bus.awlen     = len_q;
    assign bus.aruser_id = id_q;
    assign bus.awuser_id = id_q;
    assign bus.aruser_ap = ap_q;
    assign bus.awuser_ap = ap_q;
    assign bus.wdata     = wdata_s;
    assign bus.wstrb     = wstrb_s;
    assign rdata_o       = bus.rdata;
    assign busy          = (state_q != IDLE);

`ifdef CONV_ARB_BEATCHK_EN
    logic [LEN_W:0] cnt_q, cnt_d;
    logic           err_q, err_d;

    // Beat count and id checks; any violation latches err until reset.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == RDATA && bus.rvalid) begin
            cnt_d = bus.rlast ? '0 : cnt_q + 1'b1;
            if ((bus.rlast != (cnt_q == {1'b0, len_q})) || (bus.rid != id_q)) err_d = 1'b1;
            else err_d = err_d;
        end else if (state_q == WDATA && bus.wready) begin
            cnt_d = bus.wuser_last ? '0 : cnt_q + 1'b1;
            if ((bus.wuser_last != (cnt_q == {1'b0, len_q})) || (bus.wuser_id != id_q)) err_d = 1'b1;
            else err_d = err_d;
        end else if (state_q != RDATA && state_q != WDATA) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q;
        end
        if ((state_q != RDATA && bus.rvalid) || (state_q != WDATA && bus.wready)) err_d = 1'b1;
        else err_d = err_d;
    end

    // Checker state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_ids_s;
    assign unused_ids_s = ^{bus.rid, bus.wuser_id};
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_conv_bus_arb.sv
// Directed self-checking bench for conv_bus_arb (3 ports, default widths).
module tb_conv_bus_arb;
    logic clk = 1'b0;
    logic rst_n;
    logic [2:0]        cl_valid, cl_write, cl_ap, cl_ready, cl_wready, cl_rvalid, cl_rlast;
    logic [2:0][27:0]  cl_addr;
    logic [2:0][3:0]   cl_len, cl_id, cl_wstrb;
    logic [2:0][31:0]  cl_wdata;
    logic [31:0]       rdata_o;
    logic              busy, err;
    int total = 0;
    int bad   = 0;

    localparam logic CHK =
`ifdef CONV_ARB_BEATCHK_EN
        1'b1;
`else
        1'b0;
`endif

    conv_bus_arb_if #(.ADDR_W(28), .DATA_W(32), .LEN_W(4), .ID_W(4)) bus_if ();

    conv_bus_arb dut (
        .clk(clk), .rst_n(rst_n),
        .cl_valid(cl_valid), .cl_write(cl_write), .cl_addr(cl_addr),
        .cl_len(cl_len), .cl_id(cl_id), .cl_ap(cl_ap), .cl_ready(cl_ready),
        .cl_wdata(cl_wdata), .cl_wstrb(cl_wstrb), .cl_wready(cl_wready),
        .cl_rvalid(cl_rvalid), .cl_rlast(cl_rlast), .rdata_o(rdata_o),
        .bus(bus_if.master), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cl_valid = '0; cl_write = '0; cl_ap = '0;
        cl_addr = '0; cl_len = '0; cl_id = '0; cl_wdata = '0; cl_wstrb = '0;
        bus_if.arready = 1'b0; bus_if.awready = 1'b0;
        bus_if.rdata = '0; bus_if.rvalid = 1'b0; bus_if.rlast = 1'b0; bus_if.rid = '0;
        bus_if.wready = 1'b0; bus_if.wuser_last = 1'b0; bus_if.wuser_id = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // One single-beat transfer; request must already be driven in IDLE.
    task automatic xfer1(input string tag, input logic [2:0] oh, input logic wr,
                         input logic [27:0] a, input logic [3:0] id, input logic [31:0] d);
        cyc();
        chk({tag, "_addr"}, bus_if.addr, a);
        chk({tag, "_arvalid"}, bus_if.arvalid, !wr);
        chk({tag, "_awvalid"}, bus_if.awvalid, wr);
        chk({tag, "_excl"}, bus_if.arvalid & bus_if.awvalid, 1'b0);
        if (wr) bus_if.awready = 1'b1; else bus_if.arready = 1'b1;
        #1 chk({tag, "_cl_ready"}, cl_ready, oh);
        cyc();
        bus_if.arready = 1'b0; bus_if.awready = 1'b0;
        if (wr) begin
            bus_if.wready = 1'b1; bus_if.wuser_last = 1'b1; bus_if.wuser_id = id;
            #1 chk({tag, "_cl_wready"}, cl_wready, oh);
            chk({tag, "_wdata"}, bus_if.wdata, d);
        end else begin
            bus_if.rvalid = 1'b1; bus_if.rlast = 1'b1; bus_if.rid = id; bus_if.rdata = d;
            #1 chk({tag, "_cl_rvalid"}, cl_rvalid, oh);
            chk({tag, "_cl_rlast"}, cl_rlast, oh);
            chk({tag, "_rdata_o"}, rdata_o, d);
        end
        cyc();
        bus_if.rvalid = 1'b0; bus_if.rlast = 1'b0; bus_if.wready = 1'b0; bus_if.wuser_last = 1'b0;
        #1 chk({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_arvalid", bus_if.arvalid, 1'b0);
        chk("rst_awvalid", bus_if.awvalid, 1'b0);
        chk("rst_addr", bus_if.addr, 28'h0);
        chk("rst_arlen", bus_if.arlen, 4'h0);
        chk("rst_wstrb", bus_if.wstrb, 4'h0);
        chk("rst_cl_ready", cl_ready, 3'b000);
        chk("rst_err", err, 1'b0);
        cyc(); cyc();
        #1 rst_n = 1'b1;

        // Round robin: all three request, port 1 writes.
        cl_valid = 3'b111; cl_write = 3'b010;
        cl_addr[0] = 28'h000_0100; cl_addr[1] = 28'h000_0200; cl_addr[2] = 28'h000_0300;
        cl_id[0] = 4'h1; cl_id[1] = 4'h2; cl_id[2] = 4'h3;
        cl_wdata[0] = 32'h0000_AAAA; cl_wdata[1] = 32'h1111_2222; cl_wdata[2] = 32'h3333_4444;
        cl_wstrb = {4'hF, 4'hF, 4'hF};
        xfer1("rr0", 3'b001, 1'b0, 28'h000_0100, 4'h1, 32'h5A5A_0001);
        xfer1("rr1", 3'b010, 1'b1, 28'h000_0200, 4'h2, 32'h1111_2222);
        xfer1("rr2", 3'b100, 1'b0, 28'h000_0300, 4'h3, 32'h5A5A_0003);
        xfer1("rr3", 3'b001, 1'b0, 28'h000_0100, 4'h1, 32'h5A5A_0004);
        clear_inputs();

        // Read port 1, len 3, arready after two cycles.
        cyc();
        cl_valid = 3'b010; cl_addr[1] = 28'h123_4560; cl_len[1] = 4'h3; cl_id[1] = 4'h5; cl_ap[1] = 1'b1;
        #1 chk("rd_arvalid_t0", bus_if.arvalid, 1'b0);
        cyc();
        chk("rd_arvalid_t1", bus_if.arvalid, 1'b1);
        chk("rd_addr", bus_if.addr, 28'h123_4560);
        chk("rd_arlen", bus_if.arlen, 4'h3);
        chk("rd_arid", bus_if.aruser_id, 4'h5);
        chk("rd_arap", bus_if.aruser_ap, 1'b1);
        chk("rd_awvalid", bus_if.awvalid, 1'b0);
        chk("rd_cl_ready_wait", cl_ready, 3'b000);
        cyc();
        chk("rd_arvalid_hold", bus_if.arvalid, 1'b1);
        cyc();
        bus_if.arready = 1'b1;
        #1 chk("rd_cl_ready", cl_ready, 3'b010);
        cyc();
        bus_if.arready = 1'b0; cl_valid = 3'b000;
        chk("rd_arvalid_drop", bus_if.arvalid, 1'b0);
        for (int b = 0; b < 4; b++) begin
            bus_if.rvalid = 1'b1; bus_if.rdata = 32'hC0DE_0000 + b;
            bus_if.rlast = (b == 3); bus_if.rid = 4'h5;
            #1 chk("rd_cl_rvalid", cl_rvalid, 3'b010);
            chk("rd_cl_rlast", cl_rlast, (b == 3) ? 3'b010 : 3'b000);
            chk("rd_rdata_o", rdata_o, 32'hC0DE_0000 + b);
            cyc();
            if (b == 1) begin
                bus_if.rvalid = 1'b0;
                #1 chk("rd_gap_rvalid", cl_rvalid, 3'b000);
                chk("rd_gap_busy", busy, 1'b1);
                cyc();
            end
        end
        bus_if.rvalid = 1'b0; bus_if.rlast = 1'b0;
        chk("rd_busy_end", busy, 1'b0);
        chk("rd_err", err, 1'b0);

        // Write port 2, len 1, wready stalls between beats, stray rvalid.
        cl_valid = 3'b100; cl_write = 3'b100; cl_addr[2] = 28'h0AB_C000; cl_len[2] = 4'h1; cl_id[2] = 4'h9;
        cl_wdata[0] = 32'hDEAD_0000; cl_wdata[1] = 32'hBEEF_0000; cl_wdata[2] = 32'hA5A5_0001;
        cl_wstrb = {4'hF, 4'h1, 4'h2};
        cyc();
        chk("wr_awvalid", bus_if.awvalid, 1'b1);
        chk("wr_arvalid", bus_if.arvalid, 1'b0);
        chk("wr_awlen", bus_if.awlen, 4'h1);
        chk("wr_awid", bus_if.awuser_id, 4'h9);
        chk("wr_wdata_addr", bus_if.wdata, 32'h0);
        bus_if.awready = 1'b1;
        #1 chk("wr_cl_ready", cl_ready, 3'b100);
        cyc();
        bus_if.awready = 1'b0; cl_valid = 3'b000;
        bus_if.wready = 1'b1; bus_if.wuser_id = 4'h9;
        #1 chk("wr_wdata1", bus_if.wdata, 32'hA5A5_0001);
        chk("wr_wstrb1", bus_if.wstrb, 4'hF);
        chk("wr_cl_wready1", cl_wready, 3'b100);
        cyc();
        cl_wdata[2] = 32'hA5A5_0002; cl_wstrb[2] = 4'h3;
        bus_if.wready = 1'b0; bus_if.rvalid = 1'b1;
        #1 chk("wr_stall_wready", cl_wready, 3'b000);
        chk("wr_stray_rvalid", cl_rvalid, 3'b000);
        chk("wr_stall_busy", busy, 1'b1);
        cyc();
        bus_if.rvalid = 1'b0; bus_if.wready = 1'b1; bus_if.wuser_last = 1'b1;
        #1 chk("wr_wdata2", bus_if.wdata, 32'hA5A5_0002);
        chk("wr_wstrb2", bus_if.wstrb, 4'h3);
        chk("wr_cl_wready2", cl_wready, 3'b100);
        cyc();
        bus_if.wready = 1'b0; bus_if.wuser_last = 1'b0;
        #1 chk("wr_busy_end", busy, 1'b0);
        chk("wr_wstrb_idle", bus_if.wstrb, 4'h0);
        chk("wr_wdata_idle", bus_if.wdata, 32'h0);
        chk("wr_err", err, CHK);
        cyc();
        chk("wr_err_sticky", err, CHK);

        // Early rlast on beat 2 of len 3.
        do_reset();
        #1 chk("er_err_cleared", err, 1'b0);
        cl_valid = 3'b001; cl_addr[0] = 28'h000_0A00; cl_len[0] = 4'h3; cl_id[0] = 4'h2;
        cyc();
        bus_if.arready = 1'b1;
        #1 chk("er_cl_ready", cl_ready, 3'b001);
        cyc();
        bus_if.arready = 1'b0; cl_valid = 3'b000;
        bus_if.rvalid = 1'b1; bus_if.rid = 4'h2;
        #1 chk("er_cl_rvalid", cl_rvalid, 3'b001);
        cyc();
        chk("er_err_beat1", err, 1'b0);
        bus_if.rlast = 1'b1;
        #1 chk("er_cl_rlast", cl_rlast, 3'b001);
        cyc();
        bus_if.rvalid = 1'b0; bus_if.rlast = 1'b0;
        #1 chk("er_busy", busy, 1'b0);
        chk("er_err", err, CHK);

        // rid differs from the granted id.
        do_reset();
        cl_valid = 3'b100; cl_addr[2] = 28'h000_0B00; cl_len[2] = 4'h0; cl_id[2] = 4'h7;
        cyc();
        bus_if.arready = 1'b1;
        cyc();
        bus_if.arready = 1'b0; cl_valid = 3'b000;
        bus_if.rvalid = 1'b1; bus_if.rlast = 1'b1; bus_if.rid = 4'h6;
        #1 chk("id_cl_rvalid", cl_rvalid, 3'b100);
        cyc();
        bus_if.rvalid = 1'b0; bus_if.rlast = 1'b0;
        #1 chk("id_busy", busy, 1'b0);
        chk("id_err", err, CHK);

        // Reset during beat 2 of a read from port 1.
        do_reset();
        cl_valid = 3'b010; cl_addr[1] = 28'h00C_0000; cl_len[1] = 4'h3; cl_id[1] = 4'h1;
        cyc();
        bus_if.arready = 1'b1;
        cyc();
        bus_if.arready = 1'b0; cl_valid = 3'b000;
        bus_if.rvalid = 1'b1; bus_if.rid = 4'h1;
        cyc();
        #1 chk("mr_cl_rvalid_b2", cl_rvalid, 3'b010);
        rst_n = 1'b0;
        #1 chk("mr_busy", busy, 1'b0);
        chk("mr_cl_rvalid", cl_rvalid, 3'b000);
        chk("mr_addr", bus_if.addr, 28'h0);
        chk("mr_arlen", bus_if.arlen, 4'h0);
        chk("mr_arid", bus_if.aruser_id, 4'h0);
        bus_if.rvalid = 1'b0;
        #1 rst_n = 1'b1;
        cl_valid = 3'b101; cl_write = 3'b000;
        cl_addr[0] = 28'h000_0D00; cl_addr[2] = 28'h000_0E00;
        cl_len[0] = 4'h0; cl_id[0] = 4'h4; cl_id[2] = 4'h8;
        xfer1("mr_next", 3'b001, 1'b0, 28'h000_0D00, 4'h4, 32'h7777_0000);
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
